// File: rtl/seq_divide_pkg.sv
// Shared constants and FSM encoding for the sequential signed divider.
package seq_divide_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int ITER          = 16;
  localparam int LATENCY       = 17;
  localparam int CNT_W         = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divide_if.sv
// Request/result bundle between a divider user (master) and seq_divide (slave).
interface seq_divide_if
  import seq_divide_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] Ainput;
  logic [WIDTH-1:0] Binput;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, Ainput, Binput,
    input  Quotient, Remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, Ainput, Binput,
    output Quotient, Remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_divide_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < dvs <= 2^(WIDTH-1), so shifted never reaches bit WIDTH and
  // diff[WIDTH] is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divide.sv
// Sequential signed divider: 16 restoring iterations on magnitudes, then sign fix-up.
module seq_divide
  import seq_divide_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  seq_divide_if.slave bus
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_q;
  logic               neg_r;
  logic               dbz_q;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH-1:0]   q_out;
  logic [WIDTH-1:0]   r_out;
  logic               z_out;
  logic               busy_c;
  logic               done_c;
  logic               accept;

  // DONE returns to IDLE on its leaving edge, and that same edge samples
  // start, so a back-to-back request costs no extra idle cycle.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = CALC;
      CALC: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(ITER - 1)) state_nx = FIX;
      end
      FIX: begin
        busy_c   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = bus.start ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .dvs    (dvs_q),
    .rem_out(rem_nx),
    .quo_out(quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_q <= 1'b0;
      q_out <= '0;
      r_out <= '0;
      z_out <= 1'b0;
    end else begin
      if (accept) begin
        quo_q <= bus.Ainput[WIDTH-1] ? -bus.Ainput : bus.Ainput;
        dvs_q <= bus.Binput[WIDTH-1] ? -bus.Binput : bus.Binput;
        rem_q <= '0;
        neg_q <= bus.Ainput[WIDTH-1] ^ bus.Binput[WIDTH-1];
        neg_r <= bus.Ainput[WIDTH-1];
        dbz_q <= (bus.Binput == '0);
        cnt   <= '0;
      end else if (state == CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + 1'b1;
      end
      // Divide-by-zero leaves |A| in the remainder path, so only Q is forced.
      if (state == FIX) begin
        q_out <= dbz_q ? '1 : (neg_q ? -quo_q : quo_q);
        r_out <= neg_r ? -rem_q : rem_q;
        z_out <= dbz_q;
      end
    end
  end

  assign bus.Quotient    = q_out;
  assign bus.Remainder   = r_out;
  assign bus.div_by_zero = z_out;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;

endmodule
